// File: rtl/proc_io_pkg.sv
// proc_io_pkg: shared UART framing constants and transmitter state encoding.
package proc_io_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_FRAME_BITS = 10;
  localparam int UART_CLK_DIV_DEFAULT = 868;
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-2 synchronous FIFO with a registered head-of-queue output.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] head_q, head_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign wr_d = wr_q + {{AW{1'b0}}, do_push};
  assign rd_d = rd_q + {{AW{1'b0}}, do_pop};
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o = wr_q - rd_q;
  assign data_o = head_q;
  // The head register tracks the slot the next read pointer will address, forwarding a same-cycle write into it.
  assign head_d = (do_push && wr_q[AW-1:0] == rd_d[AW-1:0]) ? data_i : mem_q[rd_d[AW-1:0]];
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      head_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      head_q <= head_d;
    end
endmodule

// File: rtl/out_port_uart_tx.sv
// out_port_uart_tx: buffers output-port writes in a FIFO and sends them as UART 8N1 frames.
module out_port_uart_tx
  import proc_io_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            CLK100MHZ,
  input  logic                            rst,
  input  logic [7:0]                      wr_data,
  input  logic                            wr_en,
  output logic                            full,
  output logic [$clog2(FIFO_DEPTH):0]     level,
  output logic                            overflow,
  output logic                            busy,
  output logic                            tx
);
  localparam logic [15:0] BAUD_LOAD = 16'(CLK_DIV - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);
  tx_state_e state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [7:0] shift_q, shift_d, head;
  logic [2:0] idx_q, idx_d;
  logic tx_q, tx_d, overflow_q, empty, pop, bit_end;
  assign pop = state_q == TX_IDLE && !empty;
  assign bit_end = baud_q == '0;
  assign busy = state_q != TX_IDLE || !empty;
  assign tx = tx_q;
  assign overflow = overflow_q;
  sync_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (CLK100MHZ),
    .rst_i   (rst),
    .push_i  (wr_en),
    .pop_i   (pop),
    .data_i  (wr_data),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );
  always_ff @(posedge CLK100MHZ or posedge rst)
    if (rst) begin
      state_q <= TX_IDLE;
      baud_q <= '0;
      shift_q <= '0;
      idx_q <= '0;
      tx_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      shift_q <= shift_d;
      idx_q <= idx_d;
      tx_q <= tx_d;
      overflow_q <= overflow_q | (wr_en & full);
    end
  always_comb begin
    state_d = state_q;
    baud_d = bit_end ? baud_q : baud_q - 16'd1;
    shift_d = shift_q;
    idx_d = idx_q;
    case (state_q)
      TX_IDLE:
        if (!empty) begin
          state_d = TX_START;
          baud_d = BAUD_LOAD;
          shift_d = head;
        end
      TX_START:
        if (bit_end) begin
          state_d = TX_DATA;
          baud_d = BAUD_LOAD;
          idx_d = '0;
        end
      TX_DATA:
        if (bit_end) begin
          state_d = idx_q == LAST_BIT ? TX_STOP : TX_DATA;
          baud_d = BAUD_LOAD;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d = idx_q + 3'd1;
        end
      TX_STOP:
        if (bit_end) state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end
  // The line level is derived from the next state so the register switches on the same edge as the FSM.
  always_comb
    tx_d = state_d == TX_START ? 1'b0 : state_d == TX_DATA ? shift_d[0] : 1'b1;
endmodule
